// File: rtl/lc3_mmio_pkg.sv
// LC-3 memory-mapped I/O address map and small shared helpers.
// Used by the keyboard, display and machine-control blocks.
// Contents: device register addresses, register-select enum, KBSR word builder.
package lc3_mmio_pkg;

  localparam logic [15:0] MMIO_KBSR = 16'hFE00;  // keyboard status
  localparam logic [15:0] MMIO_KBDR = 16'hFE02;  // keyboard data
  localparam logic [15:0] MMIO_DSR  = 16'hFE04;  // display status
  localparam logic [15:0] MMIO_DDR  = 16'hFE06;  // display data
  localparam logic [15:0] MMIO_MCR  = 16'hFFFE;  // machine control

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_KBSR = 2'd1,
    REG_KBDR = 2'd2
  } kbd_reg_e;

  // Status word layout: bit15 = data ready, bit14 = interrupt enable.
  function automatic logic [15:0] kbsr_word(input logic ready, input logic ie);
    return {ready, ie, 14'b0};
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Keystroke FIFO: flop-array circular buffer with head/tail pointers and count.
// Latency: push visible at head on the edge after acceptance; head_o is combinational.
// Backpressure: caller gates push with !full; push when full / pop when empty are dropped.
// Ports: clk, rst_n (async active-low), push_i/pop_i strobes, dat_i in, head_o, count_o.
module kbd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [7:0]             dat_i,
  output logic [7:0]             head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  // Guard locally so count can never over/underflow regardless of the caller.
  assign push_ok = push_i && (count_q != (AW+1)'(DEPTH));
  assign pop_ok  = pop_i  && (count_q != '0);

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        mem_q[tail_q] <= dat_i;
        tail_q        <= tail_q + AW'(1);
      end
      if (pop_ok) head_q <= head_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/lc3_kbd_input.sv
// LC-3 keyboard device: buffers host keystrokes and exposes KBSR/KBDR to the CPU.
// Latency: rd_data/hit combinational from addr; pop, IE and irq update at the access edge.
// Backpressure: in_ready = !full from the registered count; a same-cycle pop does not free space.
// Ports: clk, reset (async active-low); host side in_char/in_valid/in_ready;
//        CPU side addr, rd_en, wr_en, wr_data, rd_data, hit; irq to the interrupt controller.
module lc3_kbd_input
  import lc3_mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] KBSR_ADDR  = MMIO_KBSR,
  parameter logic [15:0] KBDR_ADDR  = MMIO_KBDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_char,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        hit,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  kbd_reg_e      sel;
  logic [CW-1:0] count, count_nxt;
  logic [7:0]    head_dat;
  logic          push, pop, not_empty;
  logic          ie_q, ie_d;
  logic          irq_q, irq_d;
  logic [7:0]    last_q, last_d;
  logic          unused_wr;

  kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .dat_i   (in_char),
    .head_o  (head_dat),
    .count_o (count)
  );

  always_comb begin
    sel = REG_NONE;
    if (addr == KBSR_ADDR)      sel = REG_KBSR;
    else if (addr == KBDR_ADDR) sel = REG_KBDR;
  end

  assign hit       = (sel != REG_NONE);
  assign not_empty = (count != '0);
  assign in_ready  = (count != CW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = rd_en && (sel == REG_KBDR) && not_empty;

  // Only IE (bit 14) is writable; the rest of the write word is discarded.
  assign unused_wr = ^{wr_data[15], wr_data[13:0]};

  always_comb begin
    ie_d   = ie_q;
    last_d = last_q;
    if (wr_en && (sel == REG_KBSR)) ie_d = wr_data[14];
    if (pop) last_d = head_dat;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    // Look-ahead on count and IE so irq tracks the state being loaded this edge.
    irq_d = ie_d && (count_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_q   <= 1'b0;
      irq_q  <= 1'b0;
      last_q <= 8'h00;
    end else begin
      ie_q   <= ie_d;
      irq_q  <= irq_d;
      last_q <= last_d;
    end
  end

  assign irq = irq_q;

  // With the FIFO empty, KBDR keeps returning the character most recently consumed.
  always_comb begin
    rd_data = 16'h0000;
    case (sel)
      REG_KBSR: rd_data = kbsr_word(not_empty, ie_q);
      REG_KBDR: rd_data = {8'h00, not_empty ? head_dat : last_q};
      default:  rd_data = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_lc3_kbd_input.sv
// Directed self-checking bench for lc3_kbd_input (FIFO_DEPTH = 4).
// Inputs are driven 1 ns after the rising edge; outputs sampled before the next edge.
module tb_lc3_kbd_input;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        hit;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_c;

  lc3_kbd_input #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_char  (in_char),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .addr     (addr),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .hit      (hit),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("push_wait", {15'b0, in_ready}, 16'd1);
    in_char  = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addr  = a;
    rd_en = 1'b1;
    #1;
    check_eq(tag, rd_data, exp);
    tick();
    rd_en = 1'b0;
    addr  = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    addr    = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_char = 8'h00; in_valid = 1'b0; addr = KBSR;
    rd_en = 1'b0; wr_en = 1'b0; wr_data = 16'h0000;
    #3;
    // reset state
    check_eq("rst_in_ready", {15'b0, in_ready}, 16'd1);
    check_eq("rst_irq", {15'b0, irq}, 16'd0);
    check_eq("rst_kbsr", rd_data, 16'h0000);
    check_eq("rst_hit", {15'b0, hit}, 16'd1);
    #9 reset = 1'b1;
    tick();

    // single keystroke, then empty KBDR read returns last popped with no side effect
    push(8'h41);
    rd_chk("a_kbsr1", KBSR, 16'h8000);
    rd_chk("a_kbdr", KBDR, 16'h0041);
    rd_chk("a_kbsr2", KBSR, 16'h0000);
    rd_chk("a_kbdr_empty", KBDR, 16'h0041);
    rd_chk("a_kbsr3", KBSR, 16'h0000);

    // fill to depth, fifth keystroke held off
    push(8'h48); push(8'h49); push(8'h21); push(8'h0A);
    check_eq("full_rdy", {15'b0, in_ready}, 16'd0);
    in_char = 8'h5A; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    check_eq("full_hold_rdy", {15'b0, in_ready}, 16'd0);
    rd_chk("full_pop0", KBDR, 16'h0048);
    check_eq("rdy_after_pop", {15'b0, in_ready}, 16'd1);
    rd_chk("full_pop1", KBDR, 16'h0049);
    rd_chk("full_pop2", KBDR, 16'h0021);
    rd_chk("full_pop3", KBDR, 16'h000A);
    rd_chk("full_empty", KBSR, 16'h0000);

    // pop while full does not admit a push in the same cycle
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    in_char = 8'h51; in_valid = 1'b1; addr = KBDR; rd_en = 1'b1;
    #1;
    check_eq("fp_rd", rd_data, 16'h0031);
    check_eq("fp_rdy_same", {15'b0, in_ready}, 16'd0);
    tick();
    rd_en = 1'b0;
    check_eq("fp_rdy_next", {15'b0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    check_eq("fp_refull", {15'b0, in_ready}, 16'd0);
    rd_chk("fp_d0", KBDR, 16'h0032);
    rd_chk("fp_d1", KBDR, 16'h0033);
    rd_chk("fp_d2", KBDR, 16'h0034);
    rd_chk("fp_d3", KBDR, 16'h0051);

    // interrupt enable and irq timing
    wr(KBSR, 16'h4000);
    rd_chk("ie_kbsr", KBSR, 16'h4000);
    check_eq("ie_irq_empty", {15'b0, irq}, 16'd0);
    push(8'h78);
    check_eq("irq_rise", {15'b0, irq}, 16'd1);
    rd_chk("irq_kbsr", KBSR, 16'hC000);
    rd_chk("irq_pop", KBDR, 16'h0078);
    check_eq("irq_fall", {15'b0, irq}, 16'd0);
    wr(KBSR, 16'hBFFF);
    push(8'h79);
    check_eq("irq_off", {15'b0, irq}, 16'd0);
    rd_chk("irq_off_kbsr", KBSR, 16'h8000);
    rd_chk("irq_off_pop", KBDR, 16'h0079);
    wr(KBDR, 16'hFFFF);
    rd_chk("kbdr_wr_ign_sr", KBSR, 16'h0000);
    rd_chk("kbdr_wr_ign_dr", KBDR, 16'h0079);

    // simultaneous push and pop at count == 1
    push(8'h61);
    in_char = 8'h62; in_valid = 1'b1; addr = KBDR; rd_en = 1'b1;
    #1;
    check_eq("pp_rd", rd_data, 16'h0061);
    tick();
    in_valid = 1'b0; rd_en = 1'b0;
    rd_chk("pp_cnt1", KBSR, 16'h8000);
    rd_chk("pp_next", KBDR, 16'h0062);
    rd_chk("pp_empty", KBSR, 16'h0000);

    // read and write of KBSR in one cycle
    addr = KBSR; rd_en = 1'b1; wr_en = 1'b1; wr_data = 16'h4000;
    #1;
    check_eq("rw_pre", rd_data, 16'h0000);
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    rd_chk("rw_post", KBSR, 16'h4000);

    // reset mid-operation (IE still 1)
    push(8'h01); push(8'h02); push(8'h03);
    check_eq("pre_rst_irq", {15'b0, irq}, 16'd1);
    #2;
    reset = 1'b0; addr = KBSR;
    #1;
    check_eq("mrst_kbsr", rd_data, 16'h0000);
    check_eq("mrst_irq", {15'b0, irq}, 16'd0);
    check_eq("mrst_rdy", {15'b0, in_ready}, 16'd1);
    addr = KBDR;
    #1;
    check_eq("mrst_kbdr", rd_data, 16'h0000);
    reset = 1'b1;
    tick();
    rd_chk("post_rst_kbsr", KBSR, 16'h0000);

    // twelve keys with interleaved pops, pointers wrap several times
    for (int i = 0; i < 12; i++) begin
      push(8'h30 + 8'(i));
      model_q.push_back(8'h30 + 8'(i));
      if (model_q.size() >= 2) begin
        exp_c = model_q.pop_front();
        rd_chk("wrap_pop", KBDR, {8'h00, exp_c});
      end
    end
    while (model_q.size() > 0) begin
      exp_c = model_q.pop_front();
      rd_chk("wrap_drain", KBDR, {8'h00, exp_c});
    end
    rd_chk("wrap_empty", KBSR, 16'h0000);

    // address outside the keyboard registers
    addr = 16'hFE04;
    #1;
    check_eq("miss_hit", {15'b0, hit}, 16'd0);
    check_eq("miss_data", rd_data, 16'h0000);
    addr = KBDR;
    #1;
    check_eq("kbdr_hit", {15'b0, hit}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
